command_arbiter: RTL and testbench

// - Parametrised successor of the single-pair command block.
// - Merges address-load and data-write commands from N_SRC sources (vjtag, export/eth, ...) into one addr/data bus.
// - Each command produces a fixed-length strobe; downstream register logic consumes addr, data_out and sw_out.
// - Adds: per-source pending latches (no dropped requests), busy/ack handshake, soft-reset command decode

---
 rtl/command_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_command_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/command_arbiter.sv
// command_arbiter: merges per-source address-load and data-write commands
// into a single addr/data bus with fixed-length strobes, busy/ack handshake,
// soft-reset command decode and a power-on reset pulse.
// Optional feature: define CMD_RR_ARB_EN for round-robin arbitration within
// each request class; otherwise the lowest index wins.
module command_arbiter #(
  parameter int unsigned     N_SRC         = 2,
  parameter int unsigned     AW            = 8,
  parameter int unsigned     DW            = 8,
  parameter int unsigned     HOLD_CYC      = 20,
  parameter int unsigned     RST_CYC       = 50000,
  parameter logic [AW-1:0]   SOFT_RST_ADDR = 8'h01,
  parameter logic [DW-1:0]   SOFT_RST_DATA = 8'h02
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [N_SRC-1:0]      we_addr,
  input  logic [N_SRC*AW-1:0]   addr_in,
  input  logic [N_SRC-1:0]      write,
  input  logic [N_SRC*DW-1:0]   data_in,
  output logic [AW-1:0]         addr,
  output logic [DW-1:0]         data_out,
  output logic                  sw_out,
  output logic                  reset_out,
  output logic                  busy,
  output logic [N_SRC-1:0]      ack
);

  localparam int unsigned MAXC = (RST_CYC > HOLD_CYC) ? RST_CYC : HOLD_CYC;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam int unsigned IW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [CW-1:0] RST_LOAD  = CW'(RST_CYC);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_ADDR,
    S_WR,
    S_INIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [IW-1:0]   cur;
  logic [N_SRC-1:0] apend;
  logic [N_SRC-1:0] wpend;
  logic [AW-1:0]   acap [N_SRC];
  logic [DW-1:0]   dcap [N_SRC];

  logic            a_found;
  logic            w_found;
  logic [IW-1:0]   a_idx;
  logic [IW-1:0]   w_idx;
  logic            soft_hit;

`ifdef CMD_RR_ARB_EN
  logic [IW-1:0]   ptr_a;
  logic [IW-1:0]   ptr_w;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return IW'((int unsigned'(i) + 1) % N_SRC);
  endfunction
`endif

  assign soft_hit = (addr == SOFT_RST_ADDR) && (data_out == SOFT_RST_DATA);

  // Pick one pending source per class (round-robin or lowest index first)
  always_comb begin
    a_found = 1'b0;
    a_idx   = '0;
    w_found = 1'b0;
    w_idx   = '0;
`ifdef CMD_RR_ARB_EN
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!a_found && apend[(int unsigned'(ptr_a) + k) % N_SRC]) begin
        a_found = 1'b1;
        a_idx   = IW'((int unsigned'(ptr_a) + k) % N_SRC);
      end
      if (!w_found && wpend[(int unsigned'(ptr_w) + k) % N_SRC]) begin
        w_found = 1'b1;
        w_idx   = IW'((int unsigned'(ptr_w) + k) % N_SRC);
      end
    end
`else
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!a_found && apend[k]) begin
        a_found = 1'b1;
        a_idx   = IW'(k);
      end
      if (!w_found && wpend[k]) begin
        w_found = 1'b1;
        w_idx   = IW'(k);
      end
    end
`endif
  end

  // Request sampling, command FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RST;
      count     <= RST_LOAD;
      cur       <= '0;
      reset_out <= 1'b1;
      busy      <= 1'b1;
      sw_out    <= 1'b0;
      ack       <= '0;
      addr      <= '0;
      data_out  <= '0;
      apend     <= '0;
      wpend     <= '0;
`ifdef CMD_RR_ARB_EN
      ptr_a     <= '0;
      ptr_w     <= '0;
`endif
    end else begin
      ack <= '0;

      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (we_addr[i]) begin
          apend[i] <= 1'b1;
          acap[i]  <= addr_in[i*AW +: AW];
        end
        if (write[i]) begin
          wpend[i] <= 1'b1;
          dcap[i]  <= data_in[i*DW +: DW];
        end
      end

      // Pending clears below are guarded by the same-cycle request of that
      // source so a fresh request survives the ack of the current command.
      unique case (state)
        S_RST: begin
          if (count == CNT_ONE) begin
            state     <= S_IDLE;
            reset_out <= 1'b0;
            busy      <= 1'b0;
            addr      <= '0;
            data_out  <= '0;
            apend     <= '0;
            wpend     <= '0;
          end else begin
            count <= count - CNT_ONE;
          end
        end

        S_IDLE: begin
          if (soft_hit) begin
            state     <= S_RST;
            count     <= RST_LOAD;
            reset_out <= 1'b1;
            busy      <= 1'b1;
          end else if (init) begin
            state <= S_INIT;
            addr  <= '0;
            busy  <= 1'b1;
          end else if (a_found) begin
            state <= S_ADDR;
            addr  <= acap[a_idx];
            count <= HOLD_LOAD;
            cur   <= a_idx;
            busy  <= 1'b1;
`ifdef CMD_RR_ARB_EN
            ptr_a <= nxt(a_idx);
`endif
            if (HOLD_LOAD == CNT_ONE) begin
              ack[a_idx] <= 1'b1;
              if (!we_addr[a_idx]) apend[a_idx] <= 1'b0;
            end
          end else if (w_found) begin
            state    <= S_WR;
            data_out <= dcap[w_idx];
            sw_out   <= 1'b1;
            count    <= HOLD_LOAD;
            cur      <= w_idx;
            busy     <= 1'b1;
`ifdef CMD_RR_ARB_EN
            ptr_w    <= nxt(w_idx);
`endif
            if (HOLD_LOAD == CNT_ONE) begin
              ack[w_idx] <= 1'b1;
              if (!write[w_idx]) wpend[w_idx] <= 1'b0;
            end
          end
        end

        S_ADDR: begin
          if (count == CNT_ONE) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count - CNT_ONE;
            if (count == CNT_TWO) begin
              ack[cur] <= 1'b1;
              if (!we_addr[cur]) apend[cur] <= 1'b0;
            end
          end
        end

        S_WR: begin
          if (count == CNT_ONE) begin
            state  <= S_IDLE;
            sw_out <= 1'b0;
            busy   <= 1'b0;
          end else begin
            count <= count - CNT_ONE;
            if (count == CNT_TWO) begin
              ack[cur] <= 1'b1;
              if (!write[cur]) wpend[cur] <= 1'b0;
            end
          end
        end

        S_INIT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_command_arbiter.sv
// Directed testbench for command_arbiter (N_SRC=2, HOLD_CYC=4, RST_CYC=10).
module tb_command_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [1:0]  we_addr;
  logic [15:0] addr_in;
  logic [1:0]  write;
  logic [15:0] data_in;
  logic [7:0]  addr;
  logic [7:0]  data_out;
  logic        sw_out;
  logic        reset_out;
  logic        busy;
  logic [1:0]  ack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] addr_h [40];
  logic [7:0] data_h [40];
  logic       sw_h   [40];
  logic       rst_h  [40];
  logic       busy_h [40];
  logic [1:0] ack_h  [40];

  command_arbiter #(
    .N_SRC(2), .AW(8), .DW(8), .HOLD_CYC(4), .RST_CYC(10),
    .SOFT_RST_ADDR(8'h01), .SOFT_RST_DATA(8'h02)
  ) dut (
    .clk(clk), .reset(reset), .init(init), .we_addr(we_addr), .addr_in(addr_in),
    .write(write), .data_in(data_in), .addr(addr), .data_out(data_out),
    .sw_out(sw_out), .reset_out(reset_out), .busy(busy), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      addr_h[i] = addr;  data_h[i] = data_out; sw_h[i] = sw_out;
      rst_h[i]  = reset_out; busy_h[i] = busy; ack_h[i] = ack;
    end
  endtask

  task automatic addr_cmd(input logic [1:0] sel, input logic [15:0] a);
    we_addr = sel; addr_in = a;
    tick();
    we_addr = '0;
  endtask

  task automatic write_cmd(input logic [1:0] sel, input logic [15:0] d);
    write = sel; data_in = d;
    tick();
    write = '0;
  endtask

  initial begin
    int n;
    reset = 1'b1; init = 1'b0; we_addr = '0; write = '0; addr_in = '0; data_in = '0;

    // Reset state and power-on pulse
    tick(); tick(); tick();
    check("rst_reset_out", reset_out, 1);
    check("rst_busy", busy, 1);
    check("rst_sw_out", sw_out, 0);
    check("rst_ack", ack, 0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && reset_out; i++) begin
      n++;
      tick();
    end
    check("por_len", n, 10);
    check("por_addr", addr, 0);
    check("por_data", data_out, 0);
    check("por_busy", busy, 0);

    // Single write from src0
    write_cmd(2'b01, 16'h00A5);
    check("wr_lat", sw_out, 0);
    capture(10);
    check("wr_sw_first", sw_h[0], 1);
    check("wr_data", data_h[0], 8'hA5);
    check("wr_sw_last", sw_h[3], 1);
    check("wr_sw_end", sw_h[4], 0);
    check("wr_ack_early", ack_h[2], 0);
    check("wr_ack", ack_h[3], 2'b01);
    check("wr_ack_end", ack_h[4], 0);
    check("wr_busy_end", busy_h[5], 0);

    // Simultaneous address loads from both sources
    addr_cmd(2'b11, 16'h0703);
    capture(14);
    check("aa_addr0", addr_h[0], 8'h03);
    check("aa_ack0", ack_h[3], 2'b01);
    check("aa_gap_busy", busy_h[4], 0);
    check("aa_gap_addr", addr_h[4], 8'h03);
    check("aa_addr1", addr_h[5], 8'h07);
    check("aa_ack1", ack_h[8], 2'b10);
    check("aa_sw", sw_h[6], 0);

    // Lone src0 load then another pair: arbitration order depends on build
    addr_cmd(2'b01, 16'h0009);
    capture(6);
    check("a9_addr", addr_h[0], 8'h09);
    addr_cmd(2'b11, 16'h0703);
    capture(14);
`ifdef CMD_RR_ARB_EN
    check("pair2_first", addr_h[0], 8'h07);
    check("pair2_second", addr_h[5], 8'h03);
    check("pair2_ack", ack_h[3], 2'b10);
`else
    check("pair2_first", addr_h[0], 8'h03);
    check("pair2_second", addr_h[5], 8'h07);
    check("pair2_ack", ack_h[3], 2'b01);
`endif

    // Write from src1 while ADDR is busy for src0
    addr_cmd(2'b01, 16'h0020);
    tick();
    write_cmd(2'b10, 16'h5C00);
    check("pend_busy", busy, 1);
    check("pend_sw", sw_out, 0);
    capture(10);
    check("pend_addr_ack", ack_h[1], 2'b01);
    check("pend_gap_busy", busy_h[2], 0);
    check("pend_gap_sw", sw_h[2], 0);
    check("pend_sw_on", sw_h[3], 1);
    check("pend_data", data_h[3], 8'h5C);
    check("pend_wr_ack", ack_h[6], 2'b10);
    check("pend_sw_off", sw_h[7], 0);

    // Soft reset: address 01 then write 02
    addr_cmd(2'b01, 16'h0001);
    capture(6);
    write_cmd(2'b01, 16'h0002);
    capture(30);
    check("soft_pre", rst_h[4], 0);
    check("soft_on", rst_h[5], 1);
    n = 0;
    for (int i = 0; i < 30; i++) if (rst_h[i]) n++;
    check("soft_len", n, 10);
    check("soft_addr", addr_h[15], 0);
    check("soft_data", data_h[15], 0);
    check("soft_idle", busy_h[29], 0);

    // Reset mid-WR with another request pending
    write_cmd(2'b10, 16'h3300);
    tick();
    addr_cmd(2'b01, 16'h0044);
    check("mid_sw", sw_out, 1);
    reset = 1'b1;
    tick();
    check("mid_sw_off", sw_out, 0);
    check("mid_rst", reset_out, 1);
    check("mid_ack", ack, 0);
    reset = 1'b0;
    capture(20);
    n = 0;
    for (int i = 0; i < 20; i++) if (rst_h[i]) n++;
    check("mid_rst_len", n, 9);
    n = 0;
    for (int i = 0; i < 20; i++) if (ack_h[i] != 0 || sw_h[i] || addr_h[i] != 0) n++;
    check("mid_no_cmd", n, 0);
    check("mid_idle", busy_h[19], 0);

    // Init clears the address
    addr_cmd(2'b10, 16'h6600);
    capture(6);
    check("init_pre", addr, 8'h66);
    init = 1'b1;
    tick();
    init = 1'b0;
    check("init_busy", busy, 1);
    check("init_addr", addr, 0);
    tick();
    check("init_done", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
